// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment bus: debounces each digit dwell,
// decodes glyphs back to nibbles and reassembles the 32-bit display word.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [31:0] data,
  output logic [7:0]  dp,
  output logic [7:0]  digit_err,
  output logic        data_valid,
  output logic        changed
);

  typedef enum logic {TRACK, HELD} state_t;

  localparam logic [7:0] CNT_TGT = 8'(STABLE_CYCLES - 1);

  // returns {err, nibble}; unknown patterns decode to nibble 0 with err set
  function automatic logic [4:0] glyph_dec(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      s_seg_q, s_seg_d;
  logic [7:0]      s_an_q, s_an_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      seen_q, seen_d;
  logic [7:0][3:0] stage_nib_q, stage_nib_d;
  logic [7:0]      stage_err_q, stage_err_d;
  logic [7:0]      stage_dp_q, stage_dp_d;
  logic [31:0]     data_q, data_d;
  logic [7:0]      dp_q, dp_d;
  logic [7:0]      err_q, err_d;
  logic            valid_q, valid_d;
  logic            changed_q, changed_d;

  logic [7:0]      sel;
  logic            sel_ok;
  logic            in_chg;
  logic            accept;
  logic            frame_done;
  logic [4:0]      dec;

  always_comb begin
    s_seg_d = SEG;
    s_an_d  = AN;
    in_chg  = (SEG != s_seg_q) || (AN != s_an_q);
    cnt_d   = in_chg ? 8'd0 : ((cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1);

    sel    = ~s_an_q;
    sel_ok = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    // a dwell must still be intact on the accepting edge, so exactly
    // STABLE_CYCLES held cycles is not enough
    accept = sel_ok && (state_q == TRACK) && (cnt_q == CNT_TGT) && !in_chg;

    if (!sel_ok || in_chg) state_d = TRACK;
    else if (accept)       state_d = HELD;
    else                   state_d = state_q;

    dec         = glyph_dec(~s_seg_q[6:0]);
    frame_done  = (seen_q == 8'hFF);
    seen_d      = frame_done ? 8'h00 : seen_q;
    stage_nib_d = stage_nib_q;
    stage_err_d = stage_err_q;
    stage_dp_d  = stage_dp_q;
    if (accept) begin
      seen_d = seen_d | sel;
      for (int i = 0; i < 8; i++) begin
        if (sel[i]) begin
          stage_nib_d[i] = dec[3:0];
          stage_err_d[i] = dec[4];
          stage_dp_d[i]  = ~s_seg_q[7];
        end
      end
    end

    data_d    = data_q;
    dp_d      = dp_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    if (frame_done) begin
      data_d    = stage_nib_q;
      dp_d      = stage_dp_q;
      err_d     = stage_err_q;
      valid_d   = 1'b1;
      changed_d = (32'(stage_nib_q) != data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= TRACK;
      s_seg_q     <= 8'hFF;
      s_an_q      <= 8'hFF;
      cnt_q       <= 8'd0;
      seen_q      <= 8'h00;
      stage_nib_q <= '0;
      stage_err_q <= 8'h00;
      stage_dp_q  <= 8'h00;
      data_q      <= 32'h0;
      dp_q        <= 8'h00;
      err_q       <= 8'h00;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_seg_q     <= s_seg_d;
      s_an_q      <= s_an_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      stage_nib_q <= stage_nib_d;
      stage_err_q <= stage_err_d;
      stage_dp_q  <= stage_dp_d;
      data_q      <= data_d;
      dp_q        <= dp_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
    end
  end

  assign data       = data_q;
  assign dp         = dp_q;
  assign digit_err  = err_q;
  assign data_valid = valid_q;
  assign changed    = changed_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: drives SEG/AN scans and checks the
// reassembled word, flags and valid/changed pulse counts.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  SEG, AN;
  logic [31:0] data;
  logic [7:0]  dp, digit_err;
  logic        data_valid, changed;

  int n_chk = 0;
  int n_fail = 0;
  int vcnt = 0;
  int ccnt = 0;
  int v0, c0;

  logic [6:0] gtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .SEG(SEG), .AN(AN), .data(data), .dp(dp),
    .digit_err(digit_err), .data_valid(data_valid), .changed(changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) vcnt++;
    if (changed) ccnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] segv(input logic [3:0] nib, input logic dpl);
    logic [6:0] g;
    g = gtab[nib];
    return ~{dpl, g};
  endfunction

  task automatic show(input int idx, input logic [7:0] seg, input int dwell);
    AN  = ~(8'h01 << idx);
    SEG = seg;
    tick(dwell);
  endtask

  task automatic blank(input int n);
    AN  = 8'hFF;
    SEG = 8'hFF;
    tick(n);
  endtask

  task automatic scan(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 8; i++) show(i, segv(t[4*i +: 4], 1'b0), 16);
    blank(8);
  endtask

  task automatic mark;
    v0 = vcnt;
    c0 = ccnt;
  endtask

  initial begin
    logic [31:0] w;
    clr = 1'b1; SEG = 8'hFF; AN = 8'hFF;
    tick(3);
    chk("rst_data", data, 32'h0);
    chk("rst_dp", {24'h0, dp}, 32'h0);
    chk("rst_err", {24'h0, digit_err}, 32'h0);
    chk("rst_valid", {31'h0, data_valid}, 32'h0);
    chk("rst_changed", {31'h0, changed}, 32'h0);
    clr = 1'b0;
    tick(2);

    // basic scan, then identical repeat
    mark();
    scan(32'h87654321);
    chk("s1_data", data, 32'h87654321);
    chk("s1_dp", {24'h0, dp}, 32'h0);
    chk("s1_err", {24'h0, digit_err}, 32'h0);
    chk("s1_vcnt", 32'(vcnt - v0), 32'd1);
    chk("s1_ccnt", 32'(ccnt - c0), 32'd1);
    mark();
    scan(32'h87654321);
    chk("s2_vcnt", 32'(vcnt - v0), 32'd1);
    chk("s2_ccnt", 32'(ccnt - c0), 32'd0);
    chk("s2_data", data, 32'h87654321);

    // short dwells are ignored; a 5-cycle dwell is enough
    mark();
    w = 32'h89ABCDEF;
    for (int i = 0; i < 8; i++)
      show(i, segv(w[4*i +: 4], 1'b0), (i == 2) ? 3 : 16);
    blank(8);
    chk("short_vcnt", 32'(vcnt - v0), 32'd0);
    chk("short_data", data, 32'h87654321);
    show(2, segv(4'hD, 1'b0), 4);
    blank(8);
    chk("d4_vcnt", 32'(vcnt - v0), 32'd0);
    show(2, segv(4'hD, 1'b0), 5);
    blank(8);
    chk("d5_vcnt", 32'(vcnt - v0), 32'd1);
    chk("d5_data", data, 32'h89ABCDEF);
    chk("d5_ccnt", 32'(ccnt - c0), 32'd1);

    // blank digit 5 and dp on digit 0
    mark();
    w = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) show(i, 8'hFF, 16);
      else show(i, segv(w[4*i +: 4], i == 0), 16);
    end
    blank(8);
    chk("err_data", data, 32'h12045678);
    chk("err_flags", {24'h0, digit_err}, 32'h20);
    chk("err_dp", {24'h0, dp}, 32'h01);
    chk("err_vcnt", 32'(vcnt - v0), 32'd1);

    // invalid selects between digits
    mark();
    w = 32'h0F1E2D3C;
    for (int i = 0; i < 8; i++) begin
      show(i, segv(w[4*i +: 4], 1'b0), 16);
      AN = 8'hFF; SEG = segv(4'h5, 1'b0); tick(20);
      AN = 8'hFC; SEG = segv(4'h9, 1'b0); tick(20);
    end
    blank(8);
    chk("gap_data", data, 32'h0F1E2D3C);
    chk("gap_vcnt", 32'(vcnt - v0), 32'd1);
    chk("gap_err", {24'h0, digit_err}, 32'h0);

    // clr mid-frame
    for (int i = 0; i < 5; i++) show(i, segv(4'hA, 1'b0), 16);
    AN = 8'hFF; SEG = 8'hFF;
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_data", data, 32'h0);
    chk("clr_valid", {31'h0, data_valid}, 32'h0);
    mark();
    blank(4);
    show(5, segv(4'h0, 1'b0), 16);
    show(6, segv(4'h0, 1'b0), 16);
    show(7, segv(4'h0, 1'b0), 16);
    blank(8);
    chk("clr_partial_vcnt", 32'(vcnt - v0), 32'd0);
    scan(32'h0000000F);
    chk("clr_scan_data", data, 32'h0000000F);
    chk("clr_scan_vcnt", 32'(vcnt - v0), 32'd1);
    chk("clr_scan_ccnt", 32'(ccnt - c0), 32'd1);

    // out-of-order scan with digit 3 rewritten
    mark();
    show(7, segv(4'h7, 1'b0), 16);
    show(3, segv(4'h9, 1'b0), 16);
    show(0, segv(4'h0, 1'b0), 16);
    show(5, segv(4'h5, 1'b0), 16);
    show(3, segv(4'h1, 1'b0), 16);
    show(1, segv(4'h1, 1'b0), 16);
    show(6, segv(4'h6, 1'b0), 16);
    show(2, segv(4'h2, 1'b0), 16);
    show(4, segv(4'h4, 1'b0), 16);
    blank(8);
    chk("ooo_data", data, 32'h76541210);
    chk("ooo_vcnt", 32'(vcnt - v0), 32'd1);
    chk("ooo_ccnt", 32'(ccnt - c0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive side of the multiplexed 7-segment display bus that the display driver "show" produces on SEG/AN.
- Samples the active-low segment and anode lines and decodes each lit digit back to a hex nibble.
- Reassembles the full 32-bit display word and reports it with a one-cycle valid pulse.
- Used as an on-chip display monitor and self-check: its data output is compared against Leddata driven into the display driver.

Parameters:
STABLE_CYCLES, 4, consecutive sampled cycles SEG/AN must hold before a digit is accepted (legal range 2..255)

Ports:
clk  input  1  system clock
clr  input  1  synchronous active-high reset
SEG  input  8  segment lines, active low; SEG[0]=a ... SEG[6]=g, SEG[7]=dp
AN  input  8  anode selects, active low; AN[i]=0 selects digit i; digit i carries data[4i+3:4i]
data  output  32  last complete reassembled word
dp  output  8  decimal-point state per digit from the last complete frame, 1 = lit
digit_err  output  8  per-digit flag from the last frame: segment pattern was not a legal hex glyph
data_valid  output  1  one-cycle pulse when data/dp/digit_err update
changed  output  1  one-cycle pulse coincident with data_valid when the new data differs from the previous data

Behaviour:
- All state changes on the rising edge of clk. clr is synchronous.
- Reset values: data=0, dp=0, digit_err=0, data_valid=0, changed=0. Reset also clears s_seg=FF, s_an=FF, cnt=0, staging, seen mask, and sets state to TRACK.
- Input stage: SEG and AN are registered every cycle into s_seg and s_an. All decisions use the registered copies.
- Stability counter cnt, 8 bits:
  - If s_seg or s_an differs from the prior registered value, cnt is set to 0.
  - Otherwise cnt increments and saturates at 255.
- Valid select: ~s_an has exactly one bit set. AN=FF (blank) or more than one active anode is not a valid select. A non-valid select forces the state to TRACK and blocks acceptance.
- State machine:
  - TRACK: when the select is valid and cnt == STABLE_CYCLES-1, accept the digit and go to HELD.
  - HELD: stay while inputs are unchanged. On any change, return to TRACK with cnt=0.
  - Result: each dwell is accepted at most once.
  - Timing: with a new stable value present before edge k, acceptance is written at edge k+STABLE_CYCLES. A dwell of STABLE_CYCLES cycles or fewer is never accepted.
- Acceptance for digit i:
  - Look up p = ~s_seg[6:0] in the glyph table (gfedcba, active high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Match: stage_nib[i] = value, stage_err[i] = 0.
  - No match: stage_nib[i] = 0, stage_err[i] = 1.
  - stage_dp[i] = ~s_seg[7], and seen[i] is set.
  - Re-accepting a digit already in seen overwrites its staging entries; seen is unchanged.
- Frame completion:
  - On the edge after the acceptance that makes seen == FF: data, dp and digit_err load from staging and data_valid = 1.
  - changed = 1 if the new data differs from the previous data.
  - seen clears on the same edge. Staging is retained but gets overwritten as digits re-arrive.
  - An acceptance on that same edge is recorded into the freshly cleared seen.
- The very first frame after reset asserts changed if data != 0.
- data_valid and changed are high for exactly one cycle per frame. Outputs are otherwise held.
- clr mid-frame discards partial staging. The next frame needs all 8 digits to be accepted again.
- Digit scan order is irrelevant; only coverage of all 8 digits matters.

Test Plan:
- Scan 0x87654321 with legal glyphs, digits 0..7 in order, 16-cycle dwell each, dp off → after the 8th acceptance + 1 edge: data=87654321, dp=00, digit_err=00, data_valid and changed each pulse once. Second identical scan → data_valid pulses, changed=0.
- STABLE_CYCLES=4, digit 2 shown for only 3 cycles then 16 cycles of digit 3, other digits normal → no frame completes until digit 2 gets a ≥5-cycle dwell. The frame then shows the correct nibble.
- Digit 5 driven with SEG=8'hFF (blank) and SEG[7]=0 on digit 0 in an otherwise legal 0x12345678 scan → data=12045678, digit_err=20, dp=01.
- Interleave AN=FF gaps and AN=FC (two active) windows of 20 cycles between digits → no acceptance during those windows. Frame still equals the scanned value.
- Assert clr for 1 cycle after 5 digits of 0xAAAAAAAA, then scan 0x0000000F → outputs 0 after reset. The next data_valid carries 0000000F, not a mix, with changed=1.
- Scan digits in order 7,3,0,5,1,6,2,4 with digit 3 repeated as value 9 then 1 before completion → data reflects the latest value, 1. Exactly one data_valid.
